// File: rtl/vm_pkg.sv
// vm_pkg: shared types, default widths and price lookup for vm_multi.
// Holds the vm_state_e FSM encoding and the vm_price extraction helper.
package vm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CREDIT,
    VEND,
    CHANGE
  } vm_state_e;

  localparam int VM_N_ITEMS = 4;
  localparam int VM_CREDIT_W = 8;
  localparam int VM_STOCK_W = 4;
  localparam int VM_PLIST_W = 256;

  // Field idx of width w from a flat price list; caller narrows the result.
  function automatic logic [VM_PLIST_W-1:0] vm_price(
    input logic [VM_PLIST_W-1:0] list,
    input int idx,
    input int w
  );
    logic [VM_PLIST_W-1:0] mask;
    mask = (VM_PLIST_W'(1) << w) - VM_PLIST_W'(1);
    return (list >> (idx * w)) & mask;
  endfunction

endpackage

// File: rtl/vm_multi_if.sv
// vm_multi_if: coin, selection, dispense and change signals of vm_multi.
// slave = controller side, master = acceptor/actuator side; refill/sold_out with VM_STOCK_EN.
interface vm_multi_if
  import vm_pkg::*;
#(
  parameter int N_ITEMS = VM_N_ITEMS,
  parameter int CREDIT_W = VM_CREDIT_W
);
  localparam int IW = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;

  logic coin_valid;
  logic [CREDIT_W-1:0] coin_value;
  logic coin_reject;
  logic sel_valid;
  logic [IW-1:0] sel_item;
  logic sel_reject;
  logic cancel;
  logic disp_valid;
  logic [IW-1:0] disp_item;
  logic disp_ready;
  logic change_pulse;
  logic [CREDIT_W-1:0] credit;

`ifdef VM_STOCK_EN
  logic refill_valid;
  logic [IW-1:0] refill_item;
  logic [N_ITEMS-1:0] sold_out;

  modport master (
    output coin_valid, coin_value, sel_valid, sel_item,
    output cancel, disp_ready, refill_valid, refill_item,
    input coin_reject, sel_reject, disp_valid, disp_item,
    input change_pulse, credit, sold_out
  );

  modport slave (
    input coin_valid, coin_value, sel_valid, sel_item,
    input cancel, disp_ready, refill_valid, refill_item,
    output coin_reject, sel_reject, disp_valid, disp_item,
    output change_pulse, credit, sold_out
  );
`else
  modport master (
    output coin_valid, coin_value, sel_valid, sel_item,
    output cancel, disp_ready,
    input coin_reject, sel_reject, disp_valid, disp_item,
    input change_pulse, credit
  );

  modport slave (
    input coin_valid, coin_value, sel_valid, sel_item,
    input cancel, disp_ready,
    output coin_reject, sel_reject, disp_valid, disp_item,
    output change_pulse, credit
  );
`endif

endinterface

// File: rtl/vm_stock.sv
// vm_stock: per-item stock counters with refill and sold-out flags.
// Ports: clk_i, rst_ni, dec_valid_i/dec_item_i, refill_valid_i/refill_item_i, sold_out_o.
module vm_stock
  import vm_pkg::*;
#(
  parameter int N_ITEMS = VM_N_ITEMS,
  parameter int STOCK_W = VM_STOCK_W,
  parameter int STOCK_INIT = 10,
  localparam int IW = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic dec_valid_i,
  input  logic [IW-1:0] dec_item_i,
  input  logic refill_valid_i,
  input  logic [IW-1:0] refill_item_i,
  output logic [N_ITEMS-1:0] sold_out_o
);

  logic [STOCK_W-1:0] stock_q [N_ITEMS];
  logic [STOCK_W-1:0] stock_d [N_ITEMS];

  // A refill of the item being vended overrides the decrement.
  always_comb begin
    for (int i = 0; i < N_ITEMS; i++) begin
      stock_d[i] = stock_q[i];
      if (refill_valid_i && int'(refill_item_i) == i) begin
        stock_d[i] = STOCK_W'(STOCK_INIT);
      end else if (dec_valid_i && int'(dec_item_i) == i &&
                   stock_q[i] != '0) begin
        stock_d[i] = stock_q[i] - STOCK_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_ITEMS; i++) begin
        stock_q[i] <= STOCK_W'(STOCK_INIT);
      end
    end else begin
      for (int i = 0; i < N_ITEMS; i++) begin
        stock_q[i] <= stock_d[i];
      end
    end
  end

  for (genvar g = 0; g < N_ITEMS; g++) begin : g_so
    assign sold_out_o[g] = (stock_q[g] == '0);
  end

endmodule

// File: rtl/vm_multi.sv
// vm_multi: multi-product vending controller: coin credit, vend handshake, unit change.
// Ports: clock, reset (async active-low), bus (vm_multi_if.slave). VM_STOCK_EN adds stock.
module vm_multi
  import vm_pkg::*;
#(
  parameter int N_ITEMS = VM_N_ITEMS,
  parameter int CREDIT_W = VM_CREDIT_W,
  parameter int MAX_CREDIT = 200,
  parameter logic [N_ITEMS*CREDIT_W-1:0] PRICE_LIST =
    {8'd25, 8'd20, 8'd15, 8'd10},
  parameter int STOCK_W = VM_STOCK_W,
  parameter int STOCK_INIT = 10
) (
  input logic clock,
  input logic reset,
  vm_multi_if.slave bus
);

  localparam int IW = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
  localparam logic [CREDIT_W:0] MAXC = (CREDIT_W+1)'(MAX_CREDIT);

  vm_state_e state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [IW-1:0] item_q, item_d;
  logic coin_rej_q, coin_rej_d;
  logic sel_rej_q, sel_rej_d;
  logic disp_q, chg_q;

  logic [CREDIT_W-1:0] price;
  logic [CREDIT_W:0] sum;
  logic coin_ok, coin_fits, item_ok, sold, sel_ok, dec_v;

  assign price = CREDIT_W'(vm_price(VM_PLIST_W'(PRICE_LIST),
                                    int'(bus.sel_item), CREDIT_W));
  assign sum = {1'b0, credit_q} + {1'b0, bus.coin_value};
  assign coin_ok = (bus.coin_value != '0) &&
                   ({1'b0, bus.coin_value} <= MAXC);
  assign coin_fits = (sum <= MAXC);
  assign item_ok = int'(bus.sel_item) < N_ITEMS;
  assign sel_ok = item_ok && !sold && (price <= credit_q);

`ifdef VM_STOCK_EN
  logic [N_ITEMS-1:0] sold_out;

  vm_stock #(
    .N_ITEMS(N_ITEMS),
    .STOCK_W(STOCK_W),
    .STOCK_INIT(STOCK_INIT)
  ) u_stock (
    .clk_i(clock),
    .rst_ni(reset),
    .dec_valid_i(dec_v),
    .dec_item_i(bus.sel_item),
    .refill_valid_i(bus.refill_valid),
    .refill_item_i(bus.refill_item),
    .sold_out_o(sold_out)
  );

  assign sold = item_ok && sold_out[bus.sel_item];
  assign bus.sold_out = sold_out;
`else
  localparam int unused_stock = STOCK_W + STOCK_INIT;
  logic unused_dec;
  assign unused_dec = dec_v;
  assign sold = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    credit_d = credit_q;
    item_d = item_q;
    coin_rej_d = 1'b0;
    sel_rej_d = 1'b0;
    dec_v = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.coin_valid) begin
          if (coin_ok) begin
            credit_d = bus.coin_value;
            state_d = CREDIT;
          end else begin
            coin_rej_d = 1'b1;
          end
        end
        sel_rej_d = bus.sel_valid;
      end
      CREDIT: begin
        // cancel > selection > coin; a losing coin is handed back.
        if (bus.cancel) begin
          coin_rej_d = bus.coin_valid;
          state_d = CHANGE;
        end else if (bus.sel_valid) begin
          coin_rej_d = bus.coin_valid;
          if (sel_ok) begin
            credit_d = credit_q - price;
            item_d = bus.sel_item;
            dec_v = 1'b1;
            state_d = VEND;
          end else begin
            sel_rej_d = 1'b1;
          end
        end else if (bus.coin_valid) begin
          if (coin_fits) begin
            credit_d = sum[CREDIT_W-1:0];
          end else begin
            coin_rej_d = 1'b1;
          end
        end
      end
      VEND: begin
        coin_rej_d = bus.coin_valid;
        sel_rej_d = bus.sel_valid;
        if (bus.disp_ready) begin
          state_d = (credit_q != '0) ? CHANGE : IDLE;
        end
      end
      CHANGE: begin
        coin_rej_d = bus.coin_valid;
        sel_rej_d = bus.sel_valid;
        if (credit_q != '0) begin
          credit_d = credit_q - CREDIT_W'(1);
        end
        if (credit_q <= CREDIT_W'(1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      credit_q <= '0;
      item_q <= '0;
      coin_rej_q <= 1'b0;
      sel_rej_q <= 1'b0;
      disp_q <= 1'b0;
      chg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      credit_q <= credit_d;
      item_q <= item_d;
      coin_rej_q <= coin_rej_d;
      sel_rej_q <= sel_rej_d;
      disp_q <= (state_d == VEND);
      chg_q <= (state_d == CHANGE);
    end
  end

  assign bus.coin_reject = coin_rej_q;
  assign bus.sel_reject = sel_rej_q;
  assign bus.disp_valid = disp_q;
  assign bus.disp_item = item_q;
  assign bus.change_pulse = chg_q;
  assign bus.credit = credit_q;

endmodule

// File: tb/tb_vm_multi.sv
// tb_vm_multi: scoreboard bench for vm_multi with a transaction-level credit model.
// Directed scenarios then random coins/selections/cancels; VM_STOCK_EN adds stock checks.
module tb_vm_multi;
  import vm_pkg::*;

  localparam int N = 4;
  localparam int CW = 8;
  localparam int MAXC = 200;
  localparam int SINIT = 2;

  typedef struct {
    int a;
    int b;
    int cyc;
  } ev_t;

  int price [N] = '{10, 15, 20, 25};

  logic clock = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int ready_mode = 1;
  int inj_mode = 0;

  int m_credit = 0;
  int m_stock [N];
  int q_coin [$];
  int q_sel [$];
  ev_t q_disp [$];
  ev_t q_chg [$];

  vm_multi_if #(.N_ITEMS(N), .CREDIT_W(CW)) bus ();

  vm_multi #(
    .N_ITEMS(N),
    .CREDIT_W(CW),
    .MAX_CREDIT(MAXC),
    .PRICE_LIST({8'd25, 8'd20, 8'd15, 8'd10}),
    .STOCK_W(4),
    .STOCK_INIT(SINIT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got a pulse at cycle %0d, expected none", nm, cyc);
  endtask

  function automatic bit pending();
    return (q_coin.size() + q_sel.size() + q_disp.size() + q_chg.size()) != 0;
  endfunction

  function automatic bit in_stock(input int i);
`ifdef VM_STOCK_EN
    return m_stock[i] > 0;
`else
    return i >= 0;
`endif
  endfunction

  task automatic take(input int i);
`ifdef VM_STOCK_EN
    m_stock[i] = m_stock[i] - 1;
`else
    if (i < 0) $display("bad item %0d", i);
`endif
  endtask

  // Expect one change pulse per unit of credit, in descending order.
  task automatic refund(input int first);
    for (int v = m_credit; v >= 1; v--) begin
      q_chg.push_back('{v, 0, (v == m_credit) ? first : -1});
    end
    m_credit = 0;
  endtask

  task automatic clear_in();
    bus.coin_valid = 1'b0;
    bus.coin_value = '0;
    bus.sel_valid = 1'b0;
    bus.sel_item = '0;
    bus.cancel = 1'b0;
`ifdef VM_STOCK_EN
    bus.refill_valid = 1'b0;
    bus.refill_item = '0;
`endif
  endtask

  function automatic int rnd_coin();
    int p;
    p = $urandom_range(0, 19);
    if (p == 0) return 0;
    if (p == 1) return $urandom_range(201, 255);
    return $urandom_range(1, 60);
  endfunction

  task automatic drain();
    int b;
    b = 0;
    while (pending() && b < 400) begin
      @(negedge clock);
      #1;
      b++;
    end
    checks++;
    if (pending()) begin
      errors++;
      $display("FAIL drain: %0d events still pending after %0d cycles",
               q_coin.size() + q_sel.size() + q_disp.size() + q_chg.size(), b);
      q_coin.delete();
      q_sel.delete();
      q_disp.delete();
      q_chg.delete();
    end
    @(posedge clock);
    #1;
  endtask

  task automatic txn(input bit c, input int cv, input bit s, input int si,
                     input bit k, input bit r, input int ri);
    int t;
    bit busy;
    @(posedge clock);
    #1;
    t = cyc;
    busy = 1'b0;
    if (m_credit == 0) begin
      if (c) begin
        if (cv > 0 && cv <= MAXC) m_credit = cv;
        else q_coin.push_back(t + 1);
      end
      if (s) q_sel.push_back(t + 1);
    end else if (k) begin
      if (c) q_coin.push_back(t + 1);
      refund(t + 1);
      busy = 1'b1;
    end else if (s) begin
      if (c) q_coin.push_back(t + 1);
      if (si < N && price[si] <= m_credit && in_stock(si)) begin
        m_credit = m_credit - price[si];
        take(si);
        q_disp.push_back('{si, m_credit, (ready_mode == 1) ? t + 1 : -1});
        refund((ready_mode == 1) ? t + 2 : -1);
        busy = 1'b1;
      end else begin
        q_sel.push_back(t + 1);
      end
    end else if (c) begin
      if (m_credit + cv <= MAXC) m_credit = m_credit + cv;
      else q_coin.push_back(t + 1);
    end
`ifdef VM_STOCK_EN
    if (r) m_stock[ri] = SINIT;
    bus.refill_valid = r;
    bus.refill_item = 2'(ri);
`else
    if (r && ri < 0) $display("bad refill %0d", ri);
`endif
    bus.coin_valid = c;
    bus.coin_value = CW'(cv);
    bus.sel_valid = s;
    bus.sel_item = 2'(si);
    bus.cancel = k;
    @(posedge clock);
    #1;
    clear_in();
    // While vending or paying change, everything offered is refused.
    if (busy && (inj_mode == 1 || (inj_mode == 2 && $urandom_range(0, 1) == 1))) begin
      t = cyc;
      bus.coin_valid = 1'b1;
      bus.coin_value = CW'($urandom_range(1, 50));
      q_coin.push_back(t + 1);
      if ($urandom_range(0, 1) == 1) begin
        bus.sel_valid = 1'b1;
        bus.sel_item = 2'($urandom_range(0, 3));
        q_sel.push_back(t + 1);
      end
      bus.cancel = 1'($urandom_range(0, 1));
      @(posedge clock);
      #1;
      clear_in();
    end
    drain();
    chk("credit", int'(bus.credit), m_credit);
`ifdef VM_STOCK_EN
    for (int i = 0; i < N; i++) begin
      chk($sformatf("sold_out[%0d]", i), int'(bus.sold_out[i]),
          int'(m_stock[i] == 0));
    end
`endif
  endtask

  // Monitor: pops the scoreboard whenever the DUT shows an output event.
  initial begin
    ev_t d;
    forever begin
      @(negedge clock);
      if (reset) begin
        if (bus.coin_reject) begin
          if (q_coin.size() == 0) unexp("coin_reject");
          else chk("coin_reject cycle", cyc, q_coin.pop_front());
        end
        if (bus.sel_reject) begin
          if (q_sel.size() == 0) unexp("sel_reject");
          else chk("sel_reject cycle", cyc, q_sel.pop_front());
        end
        if (bus.disp_valid && bus.disp_ready) begin
          if (q_disp.size() == 0) unexp("dispense");
          else begin
            d = q_disp.pop_front();
            chk("disp_item", int'(bus.disp_item), d.a);
            chk("credit at dispense", int'(bus.credit), d.b);
            if (d.cyc >= 0) chk("dispense cycle", cyc, d.cyc);
          end
        end
        if (bus.change_pulse) begin
          if (q_chg.size() == 0) unexp("change_pulse");
          else begin
            d = q_chg.pop_front();
            chk("credit at change pulse", int'(bus.credit), d.a);
            if (d.cyc >= 0) chk("first change cycle", cyc, d.cyc);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0: bus.disp_ready = 1'($urandom_range(0, 1));
        1: bus.disp_ready = 1'b1;
        default: bus.disp_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int a, c, cv, s, si, k, r, ri;
    clear_in();
    bus.disp_ready = 1'b1;
    for (int i = 0; i < N; i++) m_stock[i] = SINIT;
    #3 reset = 1'b0;
    #2;
    chk("reset credit", int'(bus.credit), 0);
    chk("reset disp_valid", int'(bus.disp_valid), 0);
    chk("reset change_pulse", int'(bus.change_pulse), 0);
    chk("reset coin_reject", int'(bus.coin_reject), 0);
    chk("reset sel_reject", int'(bus.sel_reject), 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;

    // Exact-price vend, then vend with change.
    ready_mode = 1;
    txn(1, 10, 0, 0, 0, 0, 0);
    txn(1, 15, 0, 0, 0, 0, 0);
    txn(0, 0, 1, 3, 0, 0, 0);
    txn(1, 20, 0, 0, 0, 0, 0);
    txn(1, 10, 0, 0, 0, 0, 0);
    txn(0, 0, 1, 1, 0, 0, 0);

    // Insufficient credit, overflow, idle refusals.
    txn(0, 0, 1, 0, 0, 0, 0);
    txn(1, 0, 0, 0, 0, 0, 0);
    txn(1, 12, 0, 0, 0, 0, 0);
    txn(0, 0, 1, 2, 0, 0, 0);
    txn(1, 100, 0, 0, 0, 0, 0);
    txn(1, 83, 0, 0, 0, 0, 0);
    txn(1, 10, 0, 0, 0, 0, 0);
    txn(1, 5, 0, 0, 0, 0, 0);
    txn(1, 1, 0, 0, 0, 0, 0);
    txn(0, 0, 0, 0, 1, 0, 0);

    // Cancel beats selection; a coin during change is refused.
    inj_mode = 1;
    txn(1, 30, 0, 0, 0, 0, 0);
    txn(1, 7, 1, 1, 1, 0, 0);
    inj_mode = 0;

    // Backpressure then asynchronous reset mid-vend.
    ready_mode = 2;
    txn(1, 20, 0, 0, 0, 0, 0);
    @(posedge clock);
    #1;
    bus.sel_valid = 1'b1;
    bus.sel_item = 2'd0;
    @(posedge clock);
    #1;
    clear_in();
    repeat (5) @(posedge clock);
    #2;
    chk("disp_valid under backpressure", int'(bus.disp_valid), 1);
    chk("credit under backpressure", int'(bus.credit), 10);
    reset = 1'b0;
    #1;
    chk("abort disp_valid", int'(bus.disp_valid), 0);
    chk("abort credit", int'(bus.credit), 0);
    chk("abort change_pulse", int'(bus.change_pulse), 0);
    m_credit = 0;
    for (int i = 0; i < N; i++) m_stock[i] = SINIT;
    @(negedge clock);
    reset = 1'b1;
    ready_mode = 1;

`ifdef VM_STOCK_EN
    for (int v = 0; v < 3; v++) begin
      txn(1, 10, 0, 0, 0, 0, 0);
      txn(0, 0, 1, 0, 0, 0, 0);
    end
    txn(0, 0, 0, 0, 1, 0, 0);
    txn(0, 0, 0, 0, 0, 1, 0);
    txn(1, 10, 0, 0, 0, 0, 0);
    txn(0, 0, 1, 0, 0, 1, 0);
    for (int v = 0; v < 3; v++) begin
      txn(1, 10, 0, 0, 0, 0, 0);
      txn(0, 0, 1, 0, 0, 0, 0);
    end
    txn(0, 0, 0, 0, 1, 0, 0);
`endif

    // Random traffic with random dispense backpressure.
    ready_mode = 0;
    inj_mode = 2;
    for (int n = 0; n < 300; n++) begin
      a = $urandom_range(0, 9);
      c = 0; cv = 0; s = 0; k = 0; r = 0;
      si = $urandom_range(0, N - 1);
      ri = $urandom_range(0, N - 1);
      if (a <= 4) begin
        c = 1;
        cv = rnd_coin();
      end else if (a <= 7) begin
        s = 1;
        if ($urandom_range(0, 3) == 0) begin
          c = 1;
          cv = rnd_coin();
        end
      end else if (a == 8) begin
        k = 1;
        s = $urandom_range(0, 1);
        c = $urandom_range(0, 1);
        cv = rnd_coin();
      end else begin
        r = 1;
        s = $urandom_range(0, 1);
      end
      txn(1'(c), cv, 1'(s), si, 1'(k), 1'(r), ri);
    end

    repeat (3) @(posedge clock);
    chk("leftover scoreboard events",
        q_coin.size() + q_sel.size() + q_disp.size() + q_chg.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vm_multi.md
# vm_multi

Parametrised multi-product vending controller, successor to the single-price-ladder vending FSM. It accepts coins as unit-valued pulses and holds a saturating credit register. It vends one of `N_ITEMS` products through a valid/ready dispense handshake, then returns change as one pulse per unit. It sits between the coin acceptor front end and the dispense/change actuators, with optional per-item stock tracking.

## Interface
- `N_ITEMS`, 4: number of selectable products, minimum 2.
- `CREDIT_W`, 8: credit/price width in change units.
- `MAX_CREDIT`, 200: credit ceiling in units, at most 2^CREDIT_W−1.
- `PRICE_LIST`, {8'd25,8'd20,8'd15,8'd10}: flat `N_ITEMS*CREDIT_W` vector. Item i occupies bits [i*CREDIT_W +: CREDIT_W]. Every price is ≥1.
- `STOCK_W`, 4: stock counter width.
- `STOCK_INIT`, 10: per-item stock after reset and after refill.
- `clock` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `coin_valid` input 1: one-cycle coin-inserted strobe.
- `coin_value` input CREDIT_W: coin value in units, sampled with `coin_valid`.
- `coin_reject` output 1: one-cycle pulse that returns the just-offered coin.
- `sel_valid` input 1: one-cycle selection strobe.
- `sel_item` input $clog2(N_ITEMS): selected product index.
- `sel_reject` output 1: one-cycle pulse for a refused selection.
- `cancel` input 1: one-cycle strobe that requests a refund of the full credit.
- `disp_valid` output 1: dispense request.
- `disp_item` output $clog2(N_ITEMS): product being dispensed. Stable while `disp_valid` is high.
- `disp_ready` input 1: the actuator accepts the dispense.
- `change_pulse` output 1: one unit of change per high cycle.
- `credit` output CREDIT_W: current credit, registered.
- `refill_valid`, `refill_item`: inputs of width 1 and $clog2(N_ITEMS). Present only with `VM_STOCK_EN`.
- `sold_out` output N_ITEMS: per-item stock==0 flags. Present only with `VM_STOCK_EN`.

## Operation
- FSM states are IDLE, CREDIT, VEND and CHANGE. Reset enters IDLE.
- All outputs are 0 at reset. `credit` is 0 and every stock counter is `STOCK_INIT`.
- **IDLE.** Credit is 0.
  - A `coin_valid` with `coin_value`>0 and ≤`MAX_CREDIT` loads credit and moves to CREDIT.
  - A `coin_value` of 0 or above `MAX_CREDIT` pulses `coin_reject`.
  - `sel_valid` pulses `sel_reject`.
  - `cancel` is ignored.
- **CREDIT.**
  - **Coin handling.** If credit+`coin_value` (computed CREDIT_W+1 wide) ≤ `MAX_CREDIT`, it is added. Otherwise the coin is rejected and credit is unchanged.
  - **Selection refusal.** `sel_valid` pulses `sel_reject` and credit is unchanged if any of these holds:
    - `sel_item` ≥ `N_ITEMS`;
    - price > credit;
    - the item is sold out.
  - **Selection acceptance.** Otherwise credit −= price, stock[item] −= 1, `disp_item` is latched, and the FSM moves to VEND.
  - **Cancel.** `cancel` moves the FSM to CHANGE.
  - **Priority when several strobe in the same cycle.** `cancel` wins over `sel_valid`, which wins over `coin_valid`. A coin that loses is rejected.
- **VEND.**
  - `disp_valid` is held high until the cycle in which `disp_ready` is also high.
  - After that handshake cycle, the FSM moves to CHANGE if credit>0, otherwise to IDLE.
  - Coins, selections and cancel are rejected or ignored: coins pulse `coin_reject`, selections pulse `sel_reject`, and cancel has no effect.
- **CHANGE.**
  - `change_pulse`=1 each cycle and credit decrements by 1 per pulse.
  - The FSM moves to IDLE in the cycle after the pulse that brings credit to 0.
  - Coins, selections and cancel are rejected or ignored, as in VEND.
- An asserted `reset` mid-vend or mid-change aborts immediately. Credit is discarded, with no change paid.

## Timing
- A coin strobed at edge n is reflected in `credit` after edge n. `coin_reject` is high in cycle n+1.
- An accepted selection at edge n gives `disp_valid`=1 from cycle n+1. Minimum VEND duration is 1 cycle, when `disp_ready` is already high.
- Change of k units takes k cycles of `change_pulse`, followed by IDLE.
- Refund latency from `cancel` to the first `change_pulse` is 1 cycle.
- All outputs are registered, with no combinational input-to-output paths.

## Configuration
- `VM_STOCK_EN` defined: per-item `STOCK_W` counters, the `refill_*` ports and `sold_out`.
  - A refill sets stock[item] to `STOCK_INIT`.
  - If a refill and a vend decrement target the same item in the same cycle, the refill wins and the decrement is dropped.
  - Selection of an item with stock 0 is refused.
- `VM_STOCK_EN` undefined: stock is unlimited. The ports are absent and sold-out refusal never occurs.

## Structure
- Package `vm_pkg` holds:
  - the `vm_state_e` enum (IDLE/CREDIT/VEND/CHANGE);
  - default widths;
  - a price-extraction function.
- Sub-module `vm_stock` contains the per-item counter array plus the `sold_out` decode. It is instantiated only under `VM_STOCK_EN`.

## Test plan
- **Exact-price vend.** Coins 10 then 15, select item 3 (price 25), `disp_ready` tied high → `disp_valid` for 1 cycle, no `change_pulse`, then IDLE.
- **Vend with change.** Coin 20, coin 10, select item 1 (price 15) → dispense item 1, then 15 consecutive `change_pulse` cycles, then credit 0.
- **Insufficient credit and overflow.** Credit 12, select item 2 (price 20) → `sel_reject`, credit stays 12. Credit 195, then coin 10 → `coin_reject`, credit stays 195.
- **Cancel priority.** `cancel` and `sel_valid` together with credit 30 → no dispense, 30 change pulses. A coin during CHANGE → `coin_reject`.
- **Dispense backpressure with reset.** `disp_ready` low for 5 cycles, then asynchronous `reset` low mid-VEND → all outputs 0 immediately, IDLE, credit 0.
- **Stock exhaustion (`VM_STOCK_EN`, `STOCK_INIT`=2).**
  - Two vends of item 0, then a third → `sel_reject` and `sold_out[0]`=1.
  - A refill of item 0 in the same cycle as an accepted vend of item 0 → stock 2 afterwards.
